// File: rtl/c64_bus_pkg.sv
// rtl/c64_bus_pkg.sv - shared types and constants for the C64 bus arbiter
package c64_bus_pkg;

  localparam int         C64_ADDR_W         = 16;
  localparam logic [7:0] DEBUG_TIMEOUT_DATA = 8'hFF;

  typedef enum logic [2:0] {
    IDLE,
    STALL,
    ACCESS,
    ACK,
    RELEASE
  } arb_state_t;

endpackage

// File: rtl/c64_arb_timeout.sv
// rtl/c64_arb_timeout.sv - loadable 24-bit stall timer with clear/enable and expiry flag
module c64_arb_timeout (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        load,
  input  logic [23:0] load_value,
  input  logic        enable,
  input  logic [23:0] limit,
  output logic        expired
);

  logic [23:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (enable) begin
      count <= count + 24'd1;
    end
  end

  // Fires in the limit-th enabled cycle so the owner can act on the following edge.
  assign expired = enable && (count == limit - 24'd1);

endmodule

// File: rtl/c64_bus_arbiter.sv
// rtl/c64_bus_arbiter.sv - shares the C64 bus between the 6510 and the UART debug port
// Optional DEBUG_FREEZE_EN: debug_freeze keeps the CPU halted between debug accesses.
module c64_bus_arbiter
  import c64_bus_pkg::*;
#(
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd1000000,
  parameter int          ADDR_W         = C64_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              slot_start,
  input  logic              slot_end,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_we,
  input  logic [7:0]        cpu_data_o,
  output logic              cpu_rdy,
  input  logic              debug_request,
  input  logic              debug_we,
  input  logic [ADDR_W-1:0] debug_addr,
  input  logic [7:0]        debug_data_o,
  output logic              debug_ack,
  output logic [7:0]        debug_data_i,
  input  logic              debug_freeze,
  output logic [ADDR_W-1:0] bus_addr,
  output logic              bus_we,
  output logic [7:0]        bus_data_o,
  input  logic [7:0]        bus_data_i,
  output logic              bus_owner_dbg
);

  arb_state_t state, state_next;
  logic       grant;
  logic       timeout_hit;
  logic       expired;
  logic       timed_out;
  logic       frozen;

  c64_arb_timeout u_timeout (
    .clk        (clk),
    .reset      (reset),
    .clear      (state != STALL),
    .load       (1'b0),
    .load_value (24'd0),
    .enable     (state == STALL),
    .limit      (TIMEOUT_CYCLES),
    .expired    (expired)
  );

`ifdef DEBUG_FREEZE_EN
  logic halted;

  // Remembers that the CPU is known to be parked, so a frozen CPU needs no write-slot wait.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      halted <= 1'b0;
    end else if (grant) begin
      halted <= 1'b1;
    end else if (timeout_hit) begin
      halted <= 1'b0;
    end else if ((state == IDLE || state == RELEASE) && !debug_freeze) begin
      halted <= 1'b0;
    end
  end

  assign frozen = halted;
`else
  logic unused_debug_freeze;

  assign unused_debug_freeze = debug_freeze;
  assign frozen              = 1'b0;
`endif

  always_comb begin
    state_next  = state;
    grant       = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      IDLE: begin
        if (debug_request) state_next = STALL;
      end
      STALL: begin
        if (!debug_request) begin
          state_next = IDLE;
        end else if (slot_start && (!cpu_we || frozen)) begin
          grant      = 1'b1;
          state_next = ACCESS;
        end else if (expired) begin
          timeout_hit = 1'b1;
          state_next  = ACK;
        end
      end
      ACCESS: begin
        if (slot_end) state_next = ACK;
      end
      ACK: begin
        state_next = RELEASE;
      end
      RELEASE: begin
        if (!debug_request) state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_comb begin
    cpu_rdy = 1'b0;
    case (state)
      IDLE:         cpu_rdy = !frozen;
      ACK, RELEASE: cpu_rdy = timed_out;
      default:      cpu_rdy = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      timed_out    <= 1'b0;
      debug_data_i <= 8'h00;
    end else begin
      state <= state_next;
      if (timeout_hit) begin
        timed_out <= 1'b1;
      end else if (state == IDLE) begin
        timed_out <= 1'b0;
      end
      if (timeout_hit) begin
        debug_data_i <= DEBUG_TIMEOUT_DATA;
      end else if (state == ACCESS && slot_end && !debug_we) begin
        debug_data_i <= bus_data_i;
      end
    end
  end

  // The granted slot is owned from its slot_start cycle, before ACCESS is registered.
  assign bus_owner_dbg = (state == ACCESS) || grant;
  assign debug_ack     = (state == ACK);
  assign bus_addr      = bus_owner_dbg ? debug_addr   : cpu_addr;
  assign bus_we        = bus_owner_dbg ? debug_we     : cpu_we;
  assign bus_data_o    = bus_owner_dbg ? debug_data_o : cpu_data_o;

endmodule

// File: tb/tb_c64_bus_arbiter.sv
// tb/tb_c64_bus_arbiter.sv - self-checking bench for c64_bus_arbiter
module tb_c64_bus_arbiter;

  localparam logic [15:0] CPU_A = 16'h1234;
  localparam logic [7:0]  CPU_D = 8'h77;

  logic        clk = 1'b0;
  logic        reset;
  logic        slot_start, slot_end;
  logic [15:0] cpu_addr;
  logic        cpu_we;
  logic [7:0]  cpu_data_o;
  logic        cpu_rdy;
  logic        debug_request, debug_we;
  logic [15:0] debug_addr;
  logic [7:0]  debug_data_o;
  logic        debug_ack;
  logic [7:0]  debug_data_i;
  logic        debug_freeze;
  logic [15:0] bus_addr;
  logic        bus_we;
  logic [7:0]  bus_data_o;
  logic [7:0]  bus_data_i;
  logic        bus_owner_dbg;

  always #5 clk = ~clk;

  c64_bus_arbiter #(.TIMEOUT_CYCLES(24'd100), .ADDR_W(16)) dut (
    .clk           (clk),
    .reset         (reset),
    .slot_start    (slot_start),
    .slot_end      (slot_end),
    .cpu_addr      (cpu_addr),
    .cpu_we        (cpu_we),
    .cpu_data_o    (cpu_data_o),
    .cpu_rdy       (cpu_rdy),
    .debug_request (debug_request),
    .debug_we      (debug_we),
    .debug_addr    (debug_addr),
    .debug_data_o  (debug_data_o),
    .debug_ack     (debug_ack),
    .debug_data_i  (debug_data_i),
    .debug_freeze  (debug_freeze),
    .bus_addr      (bus_addr),
    .bus_we        (bus_we),
    .bus_data_o    (bus_data_o),
    .bus_data_i    (bus_data_i),
    .bus_owner_dbg (bus_owner_dbg)
  );

  int vectors = 0;
  int miscompares = 0;
  int ack_total = 0;

  always @(negedge clk) if (debug_ack) ack_total++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input logic r, input logic s, input logic e, input logic w,
                     input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    debug_request = r;
    slot_start    = s;
    slot_end      = e;
    cpu_we        = w;
    cpu_addr      = a;
    cpu_data_o    = d;
    #1;
  endtask

  typedef struct {
    logic        req, dwe;
    logic [15:0] daddr;
    logic [7:0]  ddata;
    logic        ss, se, cwe;
    logic [7:0]  bdi;
    logic        e_rdy, e_own, e_ack, e_bwe;
    logic [15:0] e_addr;
    logic [7:0]  e_bdo, e_dd;
  } vec_t;

  function automatic vec_t mk(input logic req, input logic dwe, input logic [15:0] daddr,
                              input logic [7:0] ddata, input logic ss, input logic se,
                              input logic cwe, input logic [7:0] bdi, input logic rdy,
                              input logic own, input logic ack, input logic [7:0] dd);
    vec_t v;
    v.req = req; v.dwe = dwe; v.daddr = daddr; v.ddata = ddata;
    v.ss = ss; v.se = se; v.cwe = cwe; v.bdi = bdi;
    v.e_rdy = rdy; v.e_own = own; v.e_ack = ack; v.e_dd = dd;
    v.e_bwe  = own ? dwe : cwe;
    v.e_addr = own ? daddr : CPU_A;
    v.e_bdo  = own ? ddata : CPU_D;
    return v;
  endfunction

  vec_t        tbl[23];
  int          stall_start, ack_before, w, hold, ackc, lastc;
  int          s[4];
  logic        done, own_seen, r, ss, se, cw, e_own, dwe;
  logic [15:0] daddr, ca;
  logic [7:0]  ddata, bdi, last_rd, exp_dd;

  initial begin
    reset = 1'b1; slot_start = 0; slot_end = 0; cpu_addr = CPU_A; cpu_we = 0;
    cpu_data_o = CPU_D; debug_request = 0; debug_we = 0; debug_addr = 0;
    debug_data_o = 0; debug_freeze = 0; bus_data_i = 0;

    // Read to D020 on CPU read cycles, then a write to 0400 behind three CPU write slots.
    tbl[0]  = mk(0, 0, 16'hD020, 8'h00, 0, 0, 0, 8'h0E, 1, 0, 0, 8'h00);
    tbl[1]  = mk(1, 0, 16'hD020, 8'h00, 0, 0, 0, 8'h0E, 1, 0, 0, 8'h00);
    tbl[2]  = mk(1, 0, 16'hD020, 8'h00, 0, 0, 0, 8'h0E, 0, 0, 0, 8'h00);
    tbl[3]  = mk(1, 0, 16'hD020, 8'h00, 1, 0, 0, 8'h0E, 0, 1, 0, 8'h00);
    tbl[4]  = mk(1, 0, 16'hD020, 8'h00, 0, 0, 0, 8'h0E, 0, 1, 0, 8'h00);
    tbl[5]  = mk(1, 0, 16'hD020, 8'h00, 0, 1, 0, 8'h0E, 0, 1, 0, 8'h00);
    tbl[6]  = mk(1, 0, 16'hD020, 8'h00, 0, 0, 0, 8'h0E, 0, 0, 1, 8'h0E);
    tbl[7]  = mk(0, 0, 16'hD020, 8'h00, 0, 0, 0, 8'h0E, 0, 0, 0, 8'h0E);
    tbl[8]  = mk(0, 0, 16'hD020, 8'h00, 0, 0, 0, 8'h0E, 1, 0, 0, 8'h0E);
    tbl[9]  = mk(1, 1, 16'h0400, 8'h41, 0, 0, 1, 8'h99, 1, 0, 0, 8'h0E);
    tbl[10] = mk(1, 1, 16'h0400, 8'h41, 1, 0, 1, 8'h99, 0, 0, 0, 8'h0E);
    tbl[11] = mk(1, 1, 16'h0400, 8'h41, 0, 0, 1, 8'h99, 0, 0, 0, 8'h0E);
    tbl[12] = mk(1, 1, 16'h0400, 8'h41, 1, 0, 1, 8'h99, 0, 0, 0, 8'h0E);
    tbl[13] = mk(1, 1, 16'h0400, 8'h41, 1, 0, 1, 8'h99, 0, 0, 0, 8'h0E);
    tbl[14] = mk(1, 1, 16'h0400, 8'h41, 0, 0, 0, 8'h99, 0, 0, 0, 8'h0E);
    tbl[15] = mk(1, 1, 16'h0400, 8'h41, 1, 0, 0, 8'h99, 0, 1, 0, 8'h0E);
    tbl[16] = mk(1, 1, 16'h0400, 8'h41, 0, 0, 0, 8'h99, 0, 1, 0, 8'h0E);
    tbl[17] = mk(1, 1, 16'h0400, 8'h41, 1, 1, 0, 8'h99, 0, 1, 0, 8'h0E);
    tbl[18] = mk(1, 1, 16'h0400, 8'h41, 0, 0, 0, 8'h99, 0, 0, 1, 8'h0E);
    tbl[19] = mk(1, 1, 16'h0400, 8'h41, 1, 0, 0, 8'h99, 0, 0, 0, 8'h0E);
    tbl[20] = mk(1, 1, 16'h0400, 8'h41, 1, 0, 0, 8'h99, 0, 0, 0, 8'h0E);
    tbl[21] = mk(0, 1, 16'h0400, 8'h41, 0, 0, 0, 8'h99, 0, 0, 0, 8'h0E);
    tbl[22] = mk(0, 1, 16'h0400, 8'h41, 0, 0, 0, 8'h99, 1, 0, 0, 8'h0E);

    repeat (2) @(negedge clk);
    #1;
    chk("reset_rdy", cpu_rdy, 1);
    chk("reset_ack", debug_ack, 0);
    chk("reset_data", debug_data_i, 0);
    chk("reset_owner", bus_owner_dbg, 0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 23; i++) begin
      debug_we = tbl[i].dwe; debug_addr = tbl[i].daddr; debug_data_o = tbl[i].ddata;
      bus_data_i = tbl[i].bdi;
      cyc(tbl[i].req, tbl[i].ss, tbl[i].se, tbl[i].cwe, CPU_A, CPU_D);
      chk($sformatf("tbl%0d_rdy", i), cpu_rdy, tbl[i].e_rdy);
      chk($sformatf("tbl%0d_own", i), bus_owner_dbg, tbl[i].e_own);
      chk($sformatf("tbl%0d_ack", i), debug_ack, tbl[i].e_ack);
      chk($sformatf("tbl%0d_bus_we", i), bus_we, tbl[i].e_bwe);
      chk($sformatf("tbl%0d_bus_addr", i), bus_addr, tbl[i].e_addr);
      chk($sformatf("tbl%0d_bus_data", i), bus_data_o, tbl[i].e_bdo);
      chk($sformatf("tbl%0d_dbg_data", i), debug_data_i, tbl[i].e_dd);
    end

    // Timeout: CPU keeps writing, ack must come 100 cycles after RDY drops.
    debug_we = 0; stall_start = -1; done = 0; own_seen = 0;
    for (int c = 0; c < 300 && !done; c++) begin
      cyc(1, (c % 4) == 1, 0, 1, CPU_A, CPU_D);
      if (bus_owner_dbg) own_seen = 1;
      if (!cpu_rdy && stall_start < 0) stall_start = c;
      if (debug_ack) begin
        chk("timeout_latency", c - stall_start, 100);
        chk("timeout_data", debug_data_i, 8'hFF);
        chk("timeout_rdy", cpu_rdy, 1);
        done = 1;
      end
    end
    chk("timeout_seen", done, 1);
    chk("timeout_no_owner", own_seen, 0);
    cyc(1, 0, 0, 1, CPU_A, CPU_D);
    chk("timeout_release_rdy", cpu_rdy, 1);
    chk("timeout_release_ack", debug_ack, 0);
    cyc(0, 0, 0, 1, CPU_A, CPU_D);
    cyc(0, 0, 0, 1, CPU_A, CPU_D);
    chk("timeout_idle_rdy", cpu_rdy, 1);

    // Request withdrawn while stalled: back to IDLE with no ack.
    ack_before = ack_total;
    cyc(1, 0, 0, 1, CPU_A, CPU_D);
    cyc(1, 1, 0, 1, CPU_A, CPU_D);
    chk("drop_stall_rdy", cpu_rdy, 0);
    cyc(0, 0, 0, 1, CPU_A, CPU_D);
    repeat (4) cyc(0, 0, 0, 0, CPU_A, CPU_D);
    chk("drop_idle_rdy", cpu_rdy, 1);
    chk("drop_no_ack", ack_total, ack_before);

    // Reset while the debug port owns the bus.
    cyc(1, 0, 0, 0, CPU_A, CPU_D);
    cyc(1, 1, 0, 0, CPU_A, CPU_D);
    cyc(1, 0, 0, 0, CPU_A, CPU_D);
    chk("rst_access_own", bus_owner_dbg, 1);
    ack_before = ack_total;
    reset = 1'b1;
    #1;
    chk("rst_async_rdy", cpu_rdy, 1);
    chk("rst_async_own", bus_owner_dbg, 0);
    chk("rst_async_addr", bus_addr, CPU_A);
    cyc(0, 0, 1, 0, CPU_A, CPU_D);
    @(negedge clk);
    reset = 1'b0;
    repeat (4) cyc(0, 0, 0, 0, CPU_A, CPU_D);
    chk("rst_no_ack", ack_total, ack_before);
    chk("rst_data", debug_data_i, 0);
    last_rd = 8'h00;

    // Random transactions checked against a slot-schedule model.
    for (int t = 0; t < 30; t++) begin
      dwe = 1'($urandom_range(0, 1)); daddr = 16'($urandom); ddata = 8'($urandom);
      bdi = 8'($urandom);
      debug_we = dwe; debug_addr = daddr; debug_data_o = ddata; bus_data_i = bdi;
      w = $urandom_range(0, 3); hold = $urandom_range(0, 3);
      s[0] = 1 + $urandom_range(0, 3);
      for (int i = 1; i <= w; i++) s[i] = s[i-1] + 3 + $urandom_range(0, 3);
      ackc = s[w] + 3; lastc = ackc + hold + 2;
      exp_dd = dwe ? last_rd : bdi;
      for (int c = 0; c <= lastc; c++) begin
        r = (c <= ackc + hold); ss = 0; se = 0;
        for (int i = 0; i <= w; i++) begin
          if (s[i] == c) ss = 1;
          if (s[i] + 2 == c) se = 1;
        end
        if (c < s[0]) cw = 1'($urandom_range(0, 1));
        else begin
          cw = 0;
          for (int i = 0; i < w; i++) if (c >= s[i] && c < s[i+1]) cw = 1;
        end
        ca = 16'($urandom);
        cyc(r, ss, se, cw, ca, 8'($urandom));
        e_own = (c >= s[w]) && (c <= s[w] + 2);
        chk($sformatf("rnd%0d_c%0d_rdy", t, c), cpu_rdy, (c == 0) || (c >= ackc + hold + 2));
        chk($sformatf("rnd%0d_c%0d_own", t, c), bus_owner_dbg, e_own);
        chk($sformatf("rnd%0d_c%0d_ack", t, c), debug_ack, c == ackc);
        chk($sformatf("rnd%0d_c%0d_addr", t, c), bus_addr, e_own ? daddr : ca);
        if (e_own) begin
          chk($sformatf("rnd%0d_c%0d_we", t, c), bus_we, dwe);
          chk($sformatf("rnd%0d_c%0d_wdata", t, c), bus_data_o, ddata);
        end
        if (c == ackc) chk($sformatf("rnd%0d_rdata", t), debug_data_i, exp_dd);
      end
      last_rd = exp_dd;
    end

`ifdef DEBUG_FREEZE_EN
    // Frozen CPU: two reads back to back, RDY stays low until freeze drops.
    debug_freeze = 1; debug_we = 0; bus_data_i = 8'h5A;
    cyc(1, 0, 0, 0, CPU_A, CPU_D);
    cyc(1, 0, 0, 0, CPU_A, CPU_D);
    cyc(1, 1, 0, 0, CPU_A, CPU_D);
    chk("frz1_own", bus_owner_dbg, 1);
    cyc(1, 0, 1, 0, CPU_A, CPU_D);
    cyc(1, 0, 0, 0, CPU_A, CPU_D);
    chk("frz1_ack", debug_ack, 1);
    chk("frz1_data", debug_data_i, 8'h5A);
    cyc(0, 0, 0, 0, CPU_A, CPU_D);
    chk("frz_release_rdy", cpu_rdy, 0);
    cyc(0, 0, 0, 0, CPU_A, CPU_D);
    chk("frz_idle_rdy", cpu_rdy, 0);
    bus_data_i = 8'hA5;
    cyc(1, 0, 0, 1, CPU_A, CPU_D);
    chk("frz2_req_rdy", cpu_rdy, 0);
    cyc(1, 1, 0, 1, CPU_A, CPU_D);
    chk("frz2_grant_on_write_slot", bus_owner_dbg, 1);
    chk("frz2_grant_rdy", cpu_rdy, 0);
    cyc(1, 0, 1, 1, CPU_A, CPU_D);
    cyc(1, 0, 0, 0, CPU_A, CPU_D);
    chk("frz2_ack", debug_ack, 1);
    chk("frz2_data", debug_data_i, 8'hA5);
    cyc(0, 0, 0, 0, CPU_A, CPU_D);
    cyc(0, 0, 0, 0, CPU_A, CPU_D);
    chk("frz2_idle_rdy", cpu_rdy, 0);
    @(negedge clk);
    debug_freeze = 0;
    #1;
    chk("frz_drop_same_cycle", cpu_rdy, 0);
    cyc(0, 0, 0, 0, CPU_A, CPU_D);
    chk("frz_drop_next_cycle", cpu_rdy, 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
